// File: rtl/uart_pkg.sv
// Shared widths and types for the UART baud tick generator.
// Divisor widths and the oversample ratio are fixed here so the interface and both modules agree.
package uart_pkg;

    localparam int DVSR_W = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;
    localparam int OVS_W  = $clog2(OVS);

    typedef logic [DVSR_W-1:0] dvsr_int_t;
    typedef logic [FRAC_W-1:0] dvsr_frac_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Bundle between the CSR block, the baud generator and the uart_tx/uart_rx datapaths.
// The master drives configuration and resync; the slave (baud generator) returns ticks and status.
interface uart_baud_gen_if;
    import uart_pkg::*;

    logic       en;
    dvsr_int_t  dvsr_int;
    dvsr_frac_t dvsr_frac;
    logic       dvsr_load;
    logic       rx_resync;
    logic       tick_ovs;
    logic       tick_tx;
    logic       rx_mid;
    logic       load_pend;
    logic       cfg_err;

    modport master (
        output en, dvsr_int, dvsr_frac, dvsr_load, rx_resync,
        input  tick_ovs, tick_tx, rx_mid, load_pend, cfg_err
    );

    modport slave (
        input  en, dvsr_int, dvsr_frac, dvsr_load, rx_resync,
        output tick_ovs, tick_tx, rx_mid, load_pend, cfg_err
    );

endinterface

// File: rtl/uart_frac_div.sv
// Fractional clock divider: period is act_int or act_int+1 clocks, averaging act_int + act_frac/2**FRAC_W.
// wrap_o is combinational and marks the last clock of each oversample period.
module uart_frac_div
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr_at_wrap,
    input  dvsr_int_t  act_int,
    input  dvsr_frac_t act_frac,
    output logic       wrap_o
);

    dvsr_int_t  cnt_q, cnt_d;
    dvsr_frac_t frac_acc_q, frac_acc_d;
    logic       carry_q, carry_d;
    dvsr_int_t  lim;
    logic       wrap;

    always_comb begin
        cnt_d      = cnt_q;
        frac_acc_d = frac_acc_q;
        carry_d    = carry_q;
        lim        = act_int - dvsr_int_t'(1) + dvsr_int_t'(carry_q);
        // >= rather than == so a divisor shrunk while frozen cannot strand cnt above lim
        wrap       = en && (cnt_q >= lim);
        if (wrap) begin
            cnt_d = '0;
            if (clr_at_wrap) begin
                frac_acc_d = '0;
                carry_d    = 1'b0;
            end else begin
                {carry_d, frac_acc_d} = {1'b0, frac_acc_q} + {1'b0, act_frac};
            end
        end else if (en) begin
            cnt_d = cnt_q + dvsr_int_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            frac_acc_q <= frac_acc_d;
            carry_q    <= carry_d;
        end
    end

    assign wrap_o = wrap;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud tick generator: oversample tick, TX bit tick and re-phasable RX mid-bit strobe.
// New divisors wait in a shadow register and go live only at a TX bit boundary (or while disabled).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DEF_INT  = 27,
    parameter int DEF_FRAC = 0
) (
    input  logic            clk,
    input  logic            rst,
    uart_baud_gen_if.slave  bg
);

    localparam logic [OVS_W-1:0] PH_LAST    = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0] PH_PRE_MID = OVS_W'(OVS / 2 - 1);

    logic [OVS_W-1:0] tx_ph_q, tx_ph_d;
    logic [OVS_W-1:0] rx_ph_q, rx_ph_d;
    dvsr_int_t        act_int_q, act_int_d, sh_int_q, sh_int_d;
    dvsr_frac_t       act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             tick_ovs_q, tick_ovs_d;
    logic             tick_tx_q, tick_tx_d;
    logic             rx_mid_q, rx_mid_d;
    logic             wrap, tx_wrap, apply, clr_at_wrap;

    // the accumulator restarts from zero whenever a new divisor goes live at a bit boundary
    assign clr_at_wrap = pend_q && (tx_ph_q == PH_LAST);

    uart_frac_div u_div (
        .clk         (clk),
        .rst         (rst),
        .en          (bg.en),
        .clr_at_wrap (clr_at_wrap),
        .act_int     (act_int_q),
        .act_frac    (act_frac_q),
        .wrap_o      (wrap)
    );

    always_comb begin
        tx_wrap    = wrap && (tx_ph_q == PH_LAST);
        apply      = pend_q && (tx_wrap || !bg.en);
        tick_ovs_d = wrap;
        tick_tx_d  = tx_wrap;
        rx_mid_d   = wrap && !bg.rx_resync && (rx_ph_q == PH_PRE_MID);
        tx_ph_d    = wrap ? tx_ph_q + OVS_W'(1) : tx_ph_q;
        if (bg.rx_resync) begin
            rx_ph_d = '0;
        end else begin
            rx_ph_d = wrap ? rx_ph_q + OVS_W'(1) : rx_ph_q;
        end

        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        err_d      = err_q;
        if (apply) begin
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
            pend_d     = 1'b0;
        end
        // a load landing on the apply edge becomes the next pending divisor
        if (bg.dvsr_load) begin
            if (bg.dvsr_int != '0) begin
                sh_int_d  = bg.dvsr_int;
                sh_frac_d = bg.dvsr_frac;
                pend_d    = 1'b1;
                err_d     = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ph_q    <= '0;
            rx_ph_q    <= '0;
            act_int_q  <= dvsr_int_t'(DEF_INT);
            act_frac_q <= dvsr_frac_t'(DEF_FRAC);
            sh_int_q   <= '0;
            sh_frac_q  <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            tick_ovs_q <= 1'b0;
            tick_tx_q  <= 1'b0;
            rx_mid_q   <= 1'b0;
        end else begin
            tx_ph_q    <= tx_ph_d;
            rx_ph_q    <= rx_ph_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            tick_ovs_q <= tick_ovs_d;
            tick_tx_q  <= tick_tx_d;
            rx_mid_q   <= rx_mid_d;
        end
    end

    assign bg.tick_ovs  = tick_ovs_q;
    assign bg.tick_tx   = tick_tx_q;
    assign bg.rx_mid    = rx_mid_q;
    assign bg.load_pend = pend_q;
    assign bg.cfg_err   = err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: integer-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed tick spacings.
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int DEF_I = 27;
    localparam int FRAC_MOD = 1 << FRAC_W;

    logic clk = 1'b0;
    logic rst;
    uart_baud_gen_if bif();

    uart_baud_gen #(.DEF_INT(DEF_I), .DEF_FRAC(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bg  (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state: divisor in use, shadow, clocks elapsed in period, fraction, phases
    int m_int, m_frac, s_int, s_frac, el, acc, m_carry, txc, rxc, sum;
    bit s_valid, m_err, mw, mtx, mapply;
    bit e_ovs = 0, e_tx = 0, e_mid = 0, e_pend = 0, e_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_int = DEF_I; m_frac = 0; s_int = 0; s_frac = 0; s_valid = 0;
            el = 0; acc = 0; m_carry = 0; txc = 0; rxc = 0; m_err = 0;
            e_ovs = 0; e_tx = 0; e_mid = 0; e_pend = 0; e_err = 0;
        end else begin
            mw     = bif.en && (el + 1 >= m_int + m_carry);
            mtx    = mw && (txc == OVS - 1);
            mapply = s_valid && (mtx || !bif.en);
            e_ovs  = mw;
            e_tx   = mtx;
            e_mid  = mw && !bif.rx_resync && (((rxc + 1) % OVS) == OVS / 2);
            if (mw) begin
                el      = 0;
                sum     = acc + m_frac;
                m_carry = sum / FRAC_MOD;
                acc     = sum % FRAC_MOD;
                txc     = (txc + 1) % OVS;
            end else if (bif.en) begin
                el++;
            end
            if (bif.rx_resync) rxc = 0;
            else if (mw) rxc = (rxc + 1) % OVS;
            if (mapply) begin
                m_int = s_int; m_frac = s_frac; s_valid = 0;
                if (mw) begin acc = 0; m_carry = 0; end
            end
            if (bif.dvsr_load) begin
                if (bif.dvsr_int != 0) begin
                    s_int = int'(bif.dvsr_int); s_frac = int'(bif.dvsr_frac);
                    s_valid = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
            e_pend = s_valid;
            e_err  = m_err;
        end
    end

    always @(negedge clk) begin
        chk("model_tick_ovs",  int'(bif.tick_ovs),  int'(e_ovs));
        chk("model_tick_tx",   int'(bif.tick_tx),   int'(e_tx));
        chk("model_rx_mid",    int'(bif.rx_mid),    int'(e_mid));
        chk("model_load_pend", int'(bif.load_pend), int'(e_pend));
        chk("model_cfg_err",   int'(bif.cfg_err),   int'(e_err));
    end

    task automatic wait_sig(input string nm, input int which, input int budget, output int t);
        int i;
        t = -1;
        i = 0;
        while (t < 0 && i < budget) begin
            @(negedge clk);
            i++;
            if ((which == 0 && bif.tick_ovs) || (which == 1 && bif.tick_tx) ||
                (which == 2 && bif.rx_mid))
                t = cyc;
        end
        if (t < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no pulse within %0d cycles, expected one", nm, budget);
            t = cyc;
        end
    endtask

    task automatic load(input int di, input int df);
        bif.dvsr_int  = DVSR_W'(di);
        bif.dvsr_frac = FRAC_W'(df);
        bif.dvsr_load = 1'b1;
        @(negedge clk);
        bif.dvsr_load = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t, t2, ta, tb, tc, td, te, tf, tg, th, ti, tj, tm, tm2, tm3, tq, pulses;
        int tk[17];

        rst = 1'b1;
        bif.en = 1'b0; bif.dvsr_int = '0; bif.dvsr_frac = '0;
        bif.dvsr_load = 1'b0; bif.rx_resync = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick_ovs", int'(bif.tick_ovs), 0);
        chk("rst_load_pend", int'(bif.load_pend), 0);
        chk("rst_cfg_err", int'(bif.cfg_err), 0);
        rst = 1'b0;

        // 1: int=4 loaded while disabled, then enable
        load(4, 0);
        chk("t1_pend_set", int'(bif.load_pend), 1);
        @(negedge clk);
        chk("t1_pend_applied_while_disabled", int'(bif.load_pend), 0);
        bif.en = 1'b1;
        t0 = cyc;
        wait_sig("t1_first_ovs", 0, 50, t);
        chk("t1_first_ovs_delay", t - t0, 4);
        wait_sig("t1_second_ovs", 0, 50, t2);
        chk("t1_ovs_spacing", t2 - t, 4);
        wait_sig("t1_first_tx", 1, 200, ta);
        chk("t1_first_tx_delay", ta - t0, 64);
        wait_sig("t1_second_tx", 1, 200, t);
        chk("t1_tx_period", t - ta, 64);

        // 2: int=4 frac=8 -> 4,4,5,4,5... after the boundary
        load(4, 8);
        chk("t2_pend_set", int'(bif.load_pend), 1);
        wait_sig("t2_apply_tx", 1, 200, ta);
        chk("t2_pend_clear", int'(bif.load_pend), 0);
        for (int k = 0; k < 17; k++) wait_sig("t2_ovs", 0, 50, tk[k]);
        chk("t2_gap0", tk[0] - ta, 4);
        chk("t2_gap1", tk[1] - tk[0], 4);
        chk("t2_gap2", tk[2] - tk[1], 5);
        chk("t2_gap3", tk[3] - tk[2], 4);
        chk("t2_16_ticks", tk[16] - tk[0], 72);

        // 3: rx resync, then resync coincident with an ovs wrap
        load(4, 0);
        wait_sig("t3_apply_tx", 1, 200, tb);
        repeat (2) @(negedge clk);
        bif.rx_resync = 1'b1;
        @(negedge clk);
        bif.rx_resync = 1'b0;
        wait_sig("t3_rx_mid", 2, 100, tm);
        chk("t3_mid_after_resync", tm - tb, 32);
        wait_sig("t3_rx_mid2", 2, 100, tm2);
        chk("t3_mid_period", tm2 - tm, 64);
        repeat (3) @(negedge clk);
        bif.rx_resync = 1'b1;
        @(negedge clk);
        bif.rx_resync = 1'b0;
        chk("t3_ovs_on_resync_wrap", int'(bif.tick_ovs), 1);
        wait_sig("t3_rx_mid3", 2, 100, tm3);
        chk("t3_mid_resync_on_wrap", tm3 - tm2, 36);

        // 4: load int=10 mid-bit
        wait_sig("t4_tx", 1, 200, tc);
        repeat (5) @(negedge clk);
        load(10, 0);
        chk("t4_pend_set", int'(bif.load_pend), 1);
        wait_sig("t4_ovs_pending", 0, 50, tq);
        chk("t4_spacing_pending", tq - tc, 8);
        wait_sig("t4_apply_tx", 1, 200, td);
        chk("t4_tx_period", td - tc, 64);
        chk("t4_pend_clear", int'(bif.load_pend), 0);
        wait_sig("t4_ovs_new", 0, 50, te);
        chk("t4_new_spacing", te - td, 10);
        wait_sig("t4_ovs_new2", 0, 50, tf);
        chk("t4_new_spacing2", tf - te, 10);

        // 5: zero divisor rejected, valid load clears the error
        load(0, 0);
        chk("t5_cfg_err_set", int'(bif.cfg_err), 1);
        chk("t5_no_pend", int'(bif.load_pend), 0);
        wait_sig("t5_ovs", 0, 50, tg);
        chk("t5_divisor_kept", tg - tf, 10);
        load(4, 0);
        chk("t5_cfg_err_clear", int'(bif.cfg_err), 0);
        chk("t5_pend_set", int'(bif.load_pend), 1);

        // 6: freeze for 20 clocks mid-period, then reset mid-bit with a pending load
        wait_sig("t6_apply_tx", 1, 400, th);
        wait_sig("t6_ovs", 0, 50, ti);
        repeat (2) @(negedge clk);
        bif.en = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            pulses += int'(bif.tick_ovs) + int'(bif.tick_tx) + int'(bif.rx_mid);
        end
        chk("t6_no_pulses_disabled", pulses, 0);
        bif.en = 1'b1;
        wait_sig("t6_resume_ovs", 0, 50, tj);
        chk("t6_resume_delay", tj - ti, 24);
        load(10, 0);
        chk("t6_pend_before_rst", int'(bif.load_pend), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tick_ovs", int'(bif.tick_ovs), 0);
        chk("t6_rst_load_pend", int'(bif.load_pend), 0);
        chk("t6_rst_cfg_err", int'(bif.cfg_err), 0);
        rst = 1'b0;
        t0 = cyc;
        wait_sig("t6_def_first_ovs", 0, 100, t);
        chk("t6_def_first_delay", t - t0, DEF_I);
        wait_sig("t6_def_second_ovs", 0, 100, t2);
        chk("t6_def_spacing", t2 - t, DEF_I);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
